// File: rtl/pll_phase_pkg.sv
// rtl/pll_phase_pkg.sv - shared types and constants for the PLL phase-shift sequencer
package pll_phase_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ROT_HI,
        S_ROT_LO,
        S_LOAD
    } state_t;

    localparam int SEL_OUT0 = 0;
    localparam int SEL_OUT2 = 1;
    localparam int SEL_OUT3 = 2;
    localparam int SEL_W    = 3;
    localparam int STEPS_W  = 8;

    localparam int DEF_SETUP_CYC    = 2;
    localparam int DEF_ROT_HIGH_CYC = 4;
    localparam int DEF_ROT_LOW_CYC  = 4;
    localparam int DEF_LOAD_CYC     = 2;
    localparam int DEF_PHASE_STEPS  = 8;

    localparam int CNT_W = 16;

    function automatic int pos_width(input int phase_steps);
        return (phase_steps <= 2) ? 1 : $clog2(phase_steps);
    endfunction

endpackage

// File: rtl/pll_phase_shift_ctrl_if.sv
// rtl/pll_phase_shift_ctrl_if.sv - step request channel between calibration logic and the sequencer
interface pll_phase_shift_ctrl_if;
    import pll_phase_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [SEL_W-1:0]   req_out_sel;
    logic               req_dir;
    logic [STEPS_W-1:0] req_steps;
    logic               done;
    logic               req_err;
    logic               lock_err;

    modport master (
        output req_valid, req_out_sel, req_dir, req_steps,
        input  req_ready, done, req_err, lock_err
    );

    modport slave (
        input  req_valid, req_out_sel, req_dir, req_steps,
        output req_ready, done, req_err, lock_err
    );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop single-bit synchroniser, cleared by reset
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_phase_shift_ctrl.sv
// rtl/pll_phase_shift_ctrl.sv - sequencer for the CCC dynamic phase-shift port with position tracking
module pll_phase_shift_ctrl
    import pll_phase_pkg::*;
#(
    parameter int SETUP_CYC    = DEF_SETUP_CYC,
    parameter int ROT_HIGH_CYC = DEF_ROT_HIGH_CYC,
    parameter int ROT_LOW_CYC  = DEF_ROT_LOW_CYC,
    parameter int LOAD_CYC     = DEF_LOAD_CYC,
    parameter int PHASE_STEPS  = DEF_PHASE_STEPS,
    localparam int POS_W       = pos_width(PHASE_STEPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    pll_phase_shift_ctrl_if.slave  req,
    input  logic                   pll_lock,
    output logic                   phase_out0_sel,
    output logic                   phase_out2_sel,
    output logic                   phase_out3_sel,
    output logic                   phase_direction,
    output logic                   phase_rotate,
    output logic                   load_phase_n,
    output logic [POS_W-1:0]       phase_pos0,
    output logic [POS_W-1:0]       phase_pos2,
    output logic [POS_W-1:0]       phase_pos3
);

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ROT_HI_LOAD = CNT_W'(ROT_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] ROT_LO_LOAD = CNT_W'(ROT_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_LOAD   = CNT_W'(LOAD_CYC - 1);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [STEPS_W-1:0] steps_left;
    logic [STEPS_W-1:0] steps_nx;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_nx;
    logic               dir_q;
    logic               dir_nx;
    logic               done_nx;
    logic               req_err_nx;
    logic               lock_err_nx;
    logic               pos_step;
    logic               lock_sync;
    logic               accept;
    logic               busy_nx;
    logic [POS_W-1:0]   pos_delta;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_sync)
    );

    assign req.req_ready = (state == S_IDLE) && lock_sync;
    assign accept        = req.req_valid && req.req_ready;
    assign busy_nx       = (state_nx != S_IDLE);
    // Retard is +(2^POS_W - 1), which wraps like -1 for a power-of-two modulus
    assign pos_delta     = dir_nx ? POS_W'(1) : {POS_W{1'b1}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        steps_nx    = steps_left;
        sel_nx      = sel_q;
        dir_nx      = dir_q;
        done_nx     = 1'b0;
        req_err_nx  = 1'b0;
        lock_err_nx = req.lock_err;
        pos_step    = 1'b0;

        if (state == S_IDLE) begin
            if (accept) begin
                sel_nx      = req.req_out_sel;
                dir_nx      = req.req_dir;
                steps_nx    = req.req_steps;
                lock_err_nx = 1'b0;
                if (!$onehot(req.req_out_sel)) begin
                    done_nx    = 1'b1;
                    req_err_nx = 1'b1;
                end else if (req.req_steps == '0) begin
                    done_nx = 1'b1;
                end else begin
                    state_nx = S_SETUP;
                    cnt_nx   = SETUP_LOAD;
                end
            end
        end else if (!lock_sync) begin
            state_nx    = S_IDLE;
            done_nx     = 1'b1;
            lock_err_nx = 1'b1;
        end else if (cnt != '0) begin
            cnt_nx = cnt - CNT_W'(1);
        end else begin
            case (state)
                S_SETUP: begin
                    state_nx = S_ROT_HI;
                    cnt_nx   = ROT_HI_LOAD;
                    pos_step = 1'b1;
                end
                S_ROT_HI: begin
                    state_nx = S_ROT_LO;
                    cnt_nx   = ROT_LO_LOAD;
                end
                S_ROT_LO: begin
                    steps_nx = steps_left - STEPS_W'(1);
                    if (steps_left == STEPS_W'(1)) begin
                        state_nx = S_LOAD;
                        cnt_nx   = LOAD_LOAD;
                    end else begin
                        state_nx = S_ROT_HI;
                        cnt_nx   = ROT_HI_LOAD;
                        pos_step = 1'b1;
                    end
                end
                S_LOAD: begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // CCC pins are registered from the next state so they line up with the FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt             <= '0;
            steps_left      <= '0;
            sel_q           <= '0;
            dir_q           <= 1'b0;
            req.done        <= 1'b0;
            req.req_err     <= 1'b0;
            req.lock_err    <= 1'b0;
            phase_out0_sel  <= 1'b0;
            phase_out2_sel  <= 1'b0;
            phase_out3_sel  <= 1'b0;
            phase_direction <= 1'b0;
            phase_rotate    <= 1'b0;
            load_phase_n    <= 1'b1;
            phase_pos0      <= '0;
            phase_pos2      <= '0;
            phase_pos3      <= '0;
        end else begin
            cnt             <= cnt_nx;
            steps_left      <= steps_nx;
            sel_q           <= sel_nx;
            dir_q           <= dir_nx;
            req.done        <= done_nx;
            req.req_err     <= req_err_nx;
            req.lock_err    <= lock_err_nx;
            phase_out0_sel  <= busy_nx && sel_nx[SEL_OUT0];
            phase_out2_sel  <= busy_nx && sel_nx[SEL_OUT2];
            phase_out3_sel  <= busy_nx && sel_nx[SEL_OUT3];
            phase_direction <= busy_nx && dir_nx;
            phase_rotate    <= (state_nx == S_ROT_HI);
            load_phase_n    <= (state_nx != S_LOAD);
            if (pos_step) begin
                if (sel_nx[SEL_OUT0]) phase_pos0 <= phase_pos0 + pos_delta;
                if (sel_nx[SEL_OUT2]) phase_pos2 <= phase_pos2 + pos_delta;
                if (sel_nx[SEL_OUT3]) phase_pos3 <= phase_pos3 + pos_delta;
            end
        end
    end

endmodule

// File: tb/tb_pll_phase_shift_ctrl.sv
// tb/tb_pll_phase_shift_ctrl.sv - self-checking bench for the PLL phase-shift sequencer
module tb_pll_phase_shift_ctrl;

    typedef struct {
        logic [2:0] sel;
        logic       dir;
        logic [7:0] steps;
        logic       exp_err;
        logic [2:0] p0;
        logic [2:0] p2;
        logic [2:0] p3;
        int         lat;
    } vec_t;

    typedef struct {
        logic       err;
        logic       lerr;
        logic [2:0] p0;
        logic [2:0] p2;
        logic [2:0] p3;
        int         rot;
        int         load;
    } sb_t;

    logic       clk;
    logic       reset;
    logic       pll_lock;
    logic       phase_out0_sel;
    logic       phase_out2_sel;
    logic       phase_out3_sel;
    logic       phase_direction;
    logic       phase_rotate;
    logic       load_phase_n;
    logic [2:0] phase_pos0;
    logic [2:0] phase_pos2;
    logic [2:0] phase_pos3;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    sb_t sb_q[$];

    pll_phase_shift_ctrl_if rif ();

    pll_phase_shift_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .req             (rif),
        .pll_lock        (pll_lock),
        .phase_out0_sel  (phase_out0_sel),
        .phase_out2_sel  (phase_out2_sel),
        .phase_out3_sel  (phase_out3_sel),
        .phase_direction (phase_direction),
        .phase_rotate    (phase_rotate),
        .load_phase_n    (load_phase_n),
        .phase_pos0      (phase_pos0),
        .phase_pos2      (phase_pos2),
        .phase_pos3      (phase_pos3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ccc_idle();
        return int'(!phase_out0_sel && !phase_out2_sel && !phase_out3_sel &&
                    !phase_rotate && !phase_direction && load_phase_n);
    endfunction

    // Scoreboard consumer: every DONE pops one expected outcome
    int  rot_cnt  = 0;
    int  load_cnt = 0;
    logic rot_prev = 1'b0;
    always @(negedge clk) begin
        sb_t e;
        if (reset) begin
            rot_cnt  = 0;
            load_cnt = 0;
            rot_prev = 1'b0;
        end else begin
            if (phase_rotate && !rot_prev) rot_cnt++;
            rot_prev = phase_rotate;
            if (!load_phase_n) load_cnt++;
            if (rif.done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected: got DONE=1 expected 0");
                end else begin
                    e = sb_q.pop_front();
                    check("sb_req_err", rif.req_err, e.err);
                    check("sb_lock_err", rif.lock_err, e.lerr);
                    check("sb_pos0", phase_pos0, e.p0);
                    check("sb_pos2", phase_pos2, e.p2);
                    check("sb_pos3", phase_pos3, e.p3);
                    check("sb_rotate_pulses", rot_cnt, e.rot);
                    check("sb_load_cycles", load_cnt, e.load);
                end
                rot_cnt  = 0;
                load_cnt = 0;
            end
        end
    end

    task automatic send(input logic [2:0] sel, input logic dir, input logic [7:0] steps,
                        input sb_t e, output int t0);
        int w = 0;
        while (!rif.req_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", rif.req_ready, 1);
        rif.req_out_sel = sel;
        rif.req_dir     = dir;
        rif.req_steps   = steps;
        rif.req_valid   = 1'b1;
        sb_q.push_back(e);
        t0 = cyc;
        @(negedge clk);
        rif.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int t0, output int lat);
        lat = -1;
        for (int k = 0; k < 3000; k++) begin
            if (rif.done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    vec_t vecs[10];

    initial begin
        sb_t e;
        int  t0;
        int  lat;
        int  sel_first, sel_n, oth_n, dir_n, rot_first, rise2, rot_hi_n, rises;
        int  load_first, load_n, done_k, ready_at_done, pos_first_rot;
        int  abort_k, ready_seen, act_seen, done_seen, w;
        logic rp;

        vecs[0] = '{3'b001, 1'b0, 8'd1,   1'b0, 3'd7, 3'd3, 3'd0, 13};
        vecs[1] = '{3'b001, 1'b1, 8'd9,   1'b0, 3'd0, 3'd3, 3'd0, 77};
        vecs[2] = '{3'b011, 1'b1, 8'd2,   1'b1, 3'd0, 3'd3, 3'd0, 1};
        vecs[3] = '{3'b000, 1'b1, 8'd4,   1'b1, 3'd0, 3'd3, 3'd0, 1};
        vecs[4] = '{3'b100, 1'b0, 8'd0,   1'b0, 3'd0, 3'd3, 3'd0, 1};
        vecs[5] = '{3'b100, 1'b0, 8'd2,   1'b0, 3'd0, 3'd3, 3'd6, 21};
        vecs[6] = '{3'b110, 1'b0, 8'd1,   1'b1, 3'd0, 3'd3, 3'd6, 1};
        vecs[7] = '{3'b010, 1'b0, 8'd5,   1'b0, 3'd0, 3'd6, 3'd6, 45};
        vecs[8] = '{3'b100, 1'b1, 8'd10,  1'b0, 3'd0, 3'd6, 3'd0, 85};
        vecs[9] = '{3'b010, 1'b1, 8'd255, 1'b0, 3'd0, 3'd5, 3'd0, 2045};

        reset           = 1'b1;
        pll_lock        = 1'b1;
        rif.req_valid   = 1'b0;
        rif.req_out_sel = 3'b000;
        rif.req_dir     = 1'b0;
        rif.req_steps   = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("reset_ccc_idle", ccc_idle(), 1);
        check("reset_done", rif.done, 0);
        check("reset_req_err", rif.req_err, 0);
        check("reset_lock_err", rif.lock_err, 0);
        check("reset_pos", {phase_pos0, phase_pos2, phase_pos3}, 0);
        check("reset_ready_c0", rif.req_ready, 0);
        @(negedge clk);
        check("reset_ready_c1", rif.req_ready, 0);
        @(negedge clk);
        check("reset_ready_c2", rif.req_ready, 1);

        // Waveform timing of one OUT2 advance by 3
        e = '{1'b0, 1'b0, 3'd0, 3'd3, 3'd0, 3, 2};
        send(3'b010, 1'b1, 8'd3, e, t0);
        sel_first = -1; sel_n = 0; oth_n = 0; dir_n = 0; rot_first = -1; rise2 = -1;
        rot_hi_n = 0; rises = 0; load_first = -1; load_n = 0; done_k = -1;
        ready_at_done = 0; pos_first_rot = -1; rp = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (phase_out2_sel) begin
                sel_n++;
                if (sel_first < 0) sel_first = k;
            end
            if (phase_out0_sel || phase_out3_sel) oth_n++;
            if (phase_direction) dir_n++;
            if (phase_rotate) begin
                rot_hi_n++;
                if (!rp) begin
                    rises++;
                    if (rises == 2) rise2 = k;
                end
                if (rot_first < 0) begin
                    rot_first = k;
                    pos_first_rot = phase_pos2;
                end
            end
            rp = phase_rotate;
            if (!load_phase_n) begin
                load_n++;
                if (load_first < 0) load_first = k;
            end
            if (rif.done && done_k < 0) begin
                done_k = k;
                ready_at_done = rif.req_ready;
            end
            @(negedge clk);
        end
        check("t_sel_rise", sel_first, 1);
        check("t_sel_cycles", sel_n, 28);
        check("t_other_sel", oth_n, 0);
        check("t_dir_cycles", dir_n, 28);
        check("t_rot_first", rot_first, 3);
        check("t_rot_second", rise2, 11);
        check("t_rot_high_cycles", rot_hi_n, 12);
        check("t_rot_pulses", rises, 3);
        check("t_pos_first_rot", pos_first_rot, 1);
        check("t_load_first", load_first, 27);
        check("t_load_cycles", load_n, 2);
        check("t_done_cycle", done_k, 29);
        check("t_ready_at_done", ready_at_done, 1);

        for (int i = 0; i < 10; i++) begin
            e.err  = vecs[i].exp_err;
            e.lerr = 1'b0;
            e.p0   = vecs[i].p0;
            e.p2   = vecs[i].p2;
            e.p3   = vecs[i].p3;
            e.rot  = (!vecs[i].exp_err && vecs[i].steps != 0) ? int'(vecs[i].steps) : 0;
            e.load = (!vecs[i].exp_err && vecs[i].steps != 0) ? 2 : 0;
            send(vecs[i].sel, vecs[i].dir, vecs[i].steps, e, t0);
            wait_done(t0, lat);
            check($sformatf("vec%0d_done_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_ccc_idle", i), ccc_idle(), 1);
        end

        // Lock loss during the third rotate-high of a 5-step OUT0 advance
        e = '{1'b0, 1'b1, 3'd3, 3'd5, 3'd0, 3, 0};
        send(3'b001, 1'b1, 8'd5, e, t0);
        rises = 0; rp = 1'b0; w = 0;
        while (rises < 3 && w < 100) begin
            if (phase_rotate && !rp) rises++;
            rp = phase_rotate;
            if (rises < 3) begin
                @(negedge clk);
                w++;
            end
        end
        check("abort_reached_third_rot", rises, 3);
        pll_lock = 1'b0;
        abort_k = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ccc_idle() == 1 && abort_k < 0) abort_k = k;
        end
        check("abort_latency", abort_k, 3);
        check("abort_lock_err", rif.lock_err, 1);
        check("abort_pos0", phase_pos0, 3);
        check("abort_ready", rif.req_ready, 0);

        // Request held while unlocked; accepted once the synchroniser sees lock
        e = '{1'b0, 1'b0, 3'd3, 3'd5, 3'd1, 1, 2};
        sb_q.push_back(e);
        rif.req_out_sel = 3'b100;
        rif.req_dir     = 1'b1;
        rif.req_steps   = 8'd1;
        rif.req_valid   = 1'b1;
        ready_seen = 0;
        act_seen   = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rif.req_ready) ready_seen++;
            if (ccc_idle() == 0) act_seen++;
        end
        check("unlocked_ready", ready_seen, 0);
        check("unlocked_activity", act_seen, 0);
        pll_lock = 1'b1;
        @(negedge clk);
        check("relock_ready_c1", rif.req_ready, 0);
        @(negedge clk);
        check("relock_ready_c2", rif.req_ready, 1);
        t0 = cyc;
        @(negedge clk);
        rif.req_valid = 1'b0;
        check("relock_sel3", phase_out3_sel, 1);
        check("relock_lock_err_cleared", rif.lock_err, 0);
        wait_done(t0, lat);
        check("relock_done_latency", lat, 13);

        // Reset during LOAD
        e = '{1'b0, 1'b0, 3'd5, 3'd5, 3'd1, 2, 2};
        send(3'b001, 1'b1, 8'd2, e, t0);
        w = 0;
        while (load_phase_n && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("rst_reached_load", load_phase_n, 0);
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("rst_load_n", load_phase_n, 1);
        check("rst_ccc_idle", ccc_idle(), 1);
        check("rst_pos", {phase_pos0, phase_pos2, phase_pos3}, 0);
        check("rst_done", rif.done, 0);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rif.done) done_seen++;
        end
        check("rst_no_done", done_seen, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
